// File: rtl/ysyx_25030077_ifu_if.sv
// Fetch-unit port bundle: the memory fetch port, the decode hand-off port and the
// redirect input.
// master = fetch unit side (drives requests and decode outputs);
// slave  = memory/decode/branch side.
interface ysyx_25030077_ifu_if;
  // memory fetch port
  logic        io_mem_req_valid;
  logic        io_mem_req_ready;
  logic [31:0] io_mem_addr;
  logic        io_mem_resp_valid;
  logic [31:0] io_mem_resp_data;
  logic        io_mem_resp_err;
  // decode hand-off
  logic        io_out_valid;
  logic        io_out_ready;
  logic [31:0] io_out_inst;
  logic [31:0] io_out_pc;
  logic        io_out_fault;
  logic [2:0]  io_imm_type;
  // control-flow redirect
  logic        io_redirect_valid;
  logic [31:0] io_redirect_pc;

  modport master (
    output io_mem_req_valid, io_mem_addr,
    input  io_mem_req_ready, io_mem_resp_valid, io_mem_resp_data, io_mem_resp_err,
    output io_out_valid, io_out_inst, io_out_pc, io_out_fault, io_imm_type,
    input  io_out_ready,
    input  io_redirect_valid, io_redirect_pc
  );

  modport slave (
    input  io_mem_req_valid, io_mem_addr,
    output io_mem_req_ready, io_mem_resp_valid, io_mem_resp_data, io_mem_resp_err,
    input  io_out_valid, io_out_inst, io_out_pc, io_out_fault, io_imm_type,
    output io_out_ready,
    output io_redirect_valid, io_redirect_pc
  );
endinterface

// File: rtl/ysyx_25030077_ifu.sv
// Instruction fetch + pre-decode: holds the PC, issues one fetch at a time,
// latches the reply and hands it to decode with its immediate-format select.
// Latency: req fire -> out_valid in 2 cycles minimum (response in the cycle after fire).
// Backpressure: decode not ready keeps the instruction held and stops further fetches.
// Ports: clock/reset (async, active-high); io = ysyx_25030077_ifu_if.master.
module ysyx_25030077_ifu #(
  parameter logic [31:0] RESET_PC = 32'h80000000
) (
  input  logic                  clock,
  input  logic                  reset,
  ysyx_25030077_ifu_if.master   io
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_HOLD} state_t;

  localparam logic [31:0] NOP_INST = 32'h00000013;

  state_t      state;
  logic [31:0] pc_q;
  logic        req_vld_q;
  logic        out_vld_q;
  logic [31:0] out_inst_q;
  logic [31:0] out_pc_q;
  logic        out_fault_q;
  logic [2:0]  imm_q;

  logic        req_fire;
  logic        out_fire;
  logic [31:0] redirect_tgt;

  // Immediate-format select from opcode and funct3.
  function automatic logic [2:0] imm_sel(input logic [6:0] opcode, input logic [2:0] funct3);
    logic [2:0] sel;
    sel = 3'd0;
    case (opcode)
      7'b0000011, 7'b1100111: sel = 3'd1;
      7'b0010011:             sel = (funct3 == 3'b001 || funct3 == 3'b101) ? 3'd5 : 3'd1;
      7'b0110111, 7'b0010111: sel = 3'd2;
      7'b1101111:             sel = 3'd3;
      7'b0100011:             sel = 3'd4;
      7'b1110011:             sel = (funct3 != 3'b000) ? 3'd6 : 3'd0;
      default:                sel = 3'd0;
    endcase
    return sel;
  endfunction

  assign req_fire     = req_vld_q & io.io_mem_req_ready;
  assign out_fire     = out_vld_q & io.io_out_ready;
  // Targets are always word aligned; low two bits are dropped.
  assign redirect_tgt = io.io_redirect_pc & ~32'd3;

  // req_valid is a register so it stays low while reset is held and first
  // rises on the clock after release; it is set whenever the next state is REQ.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_REQ;
      pc_q        <= RESET_PC;
      req_vld_q   <= 1'b0;
      out_vld_q   <= 1'b0;
      out_inst_q  <= 32'd0;
      out_pc_q    <= 32'd0;
      out_fault_q <= 1'b0;
      imm_q       <= 3'd0;
    end else if (io.io_redirect_valid) begin
      pc_q      <= redirect_tgt;
      out_vld_q <= 1'b0;
      case (state)
        // A request accepted this very cycle is still outstanding: its reply must be eaten.
        S_REQ: begin
          state     <= req_fire ? S_DROP : S_REQ;
          req_vld_q <= !req_fire;
        end
        // A reply arriving together with the redirect is simply discarded.
        S_WAIT: begin
          state     <= io.io_mem_resp_valid ? S_REQ : S_DROP;
          req_vld_q <= io.io_mem_resp_valid;
        end
        S_DROP: begin
          if (io.io_mem_resp_valid) begin
            state     <= S_REQ;
            req_vld_q <= 1'b1;
          end
        end
        default: begin
          state     <= S_REQ;
          req_vld_q <= 1'b1;
        end
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (req_fire) begin
            state     <= S_WAIT;
            req_vld_q <= 1'b0;
          end else begin
            req_vld_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (io.io_mem_resp_valid) begin
            // A faulting fetch is delivered as a nop so decode sees a harmless instruction.
            out_inst_q  <= io.io_mem_resp_err ? NOP_INST : io.io_mem_resp_data;
            out_pc_q    <= pc_q;
            out_fault_q <= io.io_mem_resp_err;
            imm_q       <= io.io_mem_resp_err ? 3'd0
                         : imm_sel(io.io_mem_resp_data[6:0], io.io_mem_resp_data[14:12]);
            out_vld_q   <= 1'b1;
            state       <= S_HOLD;
          end
        end
        S_DROP: begin
          if (io.io_mem_resp_valid) begin
            state     <= S_REQ;
            req_vld_q <= 1'b1;
          end
        end
        default: begin
          if (out_fire) begin
            pc_q      <= pc_q + 32'd4;
            out_vld_q <= 1'b0;
            state     <= S_REQ;
            req_vld_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign io.io_mem_req_valid = req_vld_q;
  assign io.io_mem_addr      = pc_q;
  assign io.io_out_valid     = out_vld_q;
  assign io.io_out_inst      = out_inst_q;
  assign io.io_out_pc        = out_pc_q;
  assign io.io_out_fault     = out_fault_q;
  assign io.io_imm_type      = imm_q;

endmodule

// File: tb/tb_ysyx_25030077_ifu.sv
module tb_ysyx_25030077_ifu;
  localparam logic [31:0] RESET_PC = 32'h80000000;
  localparam logic [6:0] OPS [10] = '{7'h03, 7'h67, 7'h13, 7'h37, 7'h17,
                                      7'h6f, 7'h23, 7'h73, 7'h33, 7'h63};

  logic clock = 1'b0;
  logic reset = 1'b1;

  ysyx_25030077_ifu_if io();
  ysyx_25030077_ifu #(.RESET_PC(RESET_PC)) dut (.clock(clock), .reset(reset), .io(io));

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
    logic [2:0]  imm;
  } exp_t;
  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } resp_t;

  exp_t  exp_q[$];   // expected decode hand-offs, in order
  resp_t resp_q[$];  // forced memory replies; random when empty

  int vectors = 0;
  int miscompares = 0;

  // stimulus knobs (percent probabilities)
  int p_ready, p_oready, p_redir, p_spur, max_delay, fix_delay;
  bit redir_now;
  logic [31:0] redir_tgt;

  // reference model state
  logic [31:0] model_pc;
  logic [31:0] req_pc;
  bit outstanding, stale;
  int delay;
  int fire_cnt = 0;
  logic [31:0] last_fire_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Immediate format from the instruction-set rules.
  function automatic logic [2:0] ref_imm(input logic [31:0] i);
    logic [6:0] op;
    logic [2:0] f3;
    op = i[6:0];
    f3 = i[14:12];
    if (op == 7'h03 || op == 7'h67) return 3'd1;
    if (op == 7'h13) return (f3 == 3'd1 || f3 == 3'd5) ? 3'd5 : 3'd1;
    if (op == 7'h37 || op == 7'h17) return 3'd2;
    if (op == 7'h6f) return 3'd3;
    if (op == 7'h23) return 3'd4;
    if (op == 7'h73 && f3 != 3'd0) return 3'd6;
    return 3'd0;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = int'($urandom_range(9));
    r[6:0] = OPS[k];
    return r;
  endfunction

  function automatic bit chance(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  // One cycle of environment behaviour, decided at the falling edge.
  task automatic step();
    bit rd, ord, rdy;
    logic [31:0] tgt;
    resp_t r;
    @(negedge clock);
    io.io_mem_resp_valid = 1'b0;
    io.io_mem_resp_data  = 32'd0;
    io.io_mem_resp_err   = 1'b0;
    io.io_redirect_valid = 1'b0;
    rd = redir_now || chance(p_redir);
    if (redir_now) tgt = redir_tgt;
    else if ($urandom_range(7) == 0) tgt = 32'hfffffff0 | ($urandom & 32'hf);
    else tgt = RESET_PC | ($urandom & 32'hfff);
    redir_now = 1'b0;

    if (outstanding || io.io_out_valid)
      check("req_while_busy", {31'd0, io.io_mem_req_valid}, 32'd0);

    // memory reply
    if (outstanding) begin
      if (delay == 0) begin
        if (resp_q.size() != 0) r = resp_q.pop_front();
        else begin
          r.data = rand_inst();
          r.err  = ($urandom_range(15) == 0);
        end
        io.io_mem_resp_valid = 1'b1;
        io.io_mem_resp_data  = r.data;
        io.io_mem_resp_err   = r.err;
        if (!stale && !rd)
          exp_q.push_back('{inst: r.err ? 32'h00000013 : r.data, pc: req_pc,
                            fault: r.err, imm: r.err ? 3'd0 : ref_imm(r.data)});
        outstanding = 1'b0;
      end else begin
        delay--;
      end
    end else if (chance(p_spur)) begin
      io.io_mem_resp_valid = 1'b1;
      io.io_mem_resp_data  = $urandom;
      io.io_mem_resp_err   = 1'($urandom_range(1));
    end

    // decode side
    ord = chance(p_oready);
    io.io_out_ready = ord;
    if (io.io_out_valid) begin
      if (rd) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end else if (ord) begin
        model_pc = model_pc + 32'd4;
      end
    end

    // fetch request side
    rdy = chance(p_ready);
    io.io_mem_req_ready = rdy;
    if (io.io_mem_req_valid && rdy) begin
      check("fetch_addr", io.io_mem_addr, model_pc);
      fire_cnt++;
      last_fire_addr = io.io_mem_addr;
      outstanding = 1'b1;
      stale = 1'b0;
      req_pc = model_pc;
      delay = (fix_delay >= 0) ? fix_delay : int'($urandom_range(max_delay));
    end

    if (rd) begin
      io.io_redirect_valid = 1'b1;
      io.io_redirect_pc    = tgt;
      model_pc = tgt & ~32'd3;
      if (outstanding) stale = 1'b1;
    end
  endtask

  // Scoreboard monitor: compares every accepted hand-off against the queue.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      #1;
      if (!reset && io.io_out_valid && io.io_out_ready && !io.io_redirect_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL out_unexpected: got pc %h inst %h, required no hand-off",
                   io.io_out_pc, io.io_out_inst);
        end else begin
          e = exp_q.pop_front();
          check("out_inst",  io.io_out_inst, e.inst);
          check("out_pc",    io.io_out_pc, e.pc);
          check("out_fault", {31'd0, io.io_out_fault}, {31'd0, e.fault});
          check("imm_type",  {29'd0, io.io_imm_type}, {29'd0, e.imm});
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    miscompares++;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

  task automatic wait_fire(input string name, input bool_out_idle);
    int n;
    n = fire_cnt;
    for (int i = 0; i < 20 && fire_cnt == n; i++) begin
      step();
      if (bool_out_idle) check({name, "_no_out"}, {31'd0, io.io_out_valid}, 32'd0);
    end
    check({name, "_fired"}, 32'(fire_cnt - n), 32'd1);
  endtask

  initial begin : main
    io.io_mem_req_ready = 1'b0;
    io.io_mem_resp_valid = 1'b0;
    io.io_mem_resp_data = 32'd0;
    io.io_mem_resp_err = 1'b0;
    io.io_out_ready = 1'b0;
    io.io_redirect_valid = 1'b0;
    io.io_redirect_pc = 32'd0;
    p_ready = 100; p_oready = 0; p_redir = 0; p_spur = 0;
    max_delay = 0; fix_delay = 0; redir_now = 1'b0; redir_tgt = 32'd0;
    model_pc = RESET_PC; req_pc = RESET_PC; outstanding = 1'b0; stale = 1'b0; delay = 0;
    last_fire_addr = 32'd0;

    // reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_req_valid", {31'd0, io.io_mem_req_valid}, 32'd0);
    check("rst_addr", io.io_mem_addr, RESET_PC);
    check("rst_out_valid", {31'd0, io.io_out_valid}, 32'd0);
    check("rst_inst", io.io_out_inst, 32'd0);
    check("rst_pc", io.io_out_pc, 32'd0);
    check("rst_fault", {31'd0, io.io_out_fault}, 32'd0);
    check("rst_imm", {29'd0, io.io_imm_type}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // first fetch, single-cycle reply, then 5 cycles of decode stall
    resp_q.push_back('{data: 32'h00500093, err: 1'b0});
    wait_fire("first", 1'b1);
    check("first_addr", last_fire_addr, RESET_PC);
    check("lat0_valid", {31'd0, io.io_out_valid}, 32'd0);
    step();
    check("lat1_valid", {31'd0, io.io_out_valid}, 32'd0);
    step();
    check("lat2_valid", {31'd0, io.io_out_valid}, 32'd1);
    check("first_pc", io.io_out_pc, RESET_PC);
    check("first_inst", io.io_out_inst, 32'h00500093);
    check("first_imm", {29'd0, io.io_imm_type}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_valid", {31'd0, io.io_out_valid}, 32'd1);
      check("hold_inst", io.io_out_inst, 32'h00500093);
      check("hold_pc", io.io_out_pc, RESET_PC);
      check("hold_no_req", {31'd0, io.io_mem_req_valid}, 32'd0);
    end
    p_oready = 100;
    step();
    p_oready = 0;
    step();
    check("next_req_valid", {31'd0, io.io_mem_req_valid}, 32'd1);
    check("next_addr", io.io_mem_addr, RESET_PC + 32'd4);

    // redirect while waiting, reply 3 cycles later must vanish
    p_oready = 100;
    fix_delay = 3;
    wait_fire("pre_redir", 1'b0);
    redir_now = 1'b1;
    redir_tgt = 32'h80000102;
    step();
    wait_fire("after_redir", 1'b1);
    check("redir_addr", last_fire_addr, 32'h80000100);

    // faulting reply for the fetch just issued
    fix_delay = 0;
    p_oready = 0;
    resp_q.push_back('{data: 32'h00a00113, err: 1'b1});
    for (int i = 0; i < 10 && !io.io_out_valid; i++) step();
    check("fault_valid", {31'd0, io.io_out_valid}, 32'd1);
    check("fault_flag", {31'd0, io.io_out_fault}, 32'd1);
    check("fault_inst", io.io_out_inst, 32'h00000013);
    check("fault_imm", {29'd0, io.io_imm_type}, 32'd0);
    check("fault_pc", io.io_out_pc, 32'h80000100);
    p_oready = 100;
    step();
    step();
    check("fault_next_addr", io.io_mem_addr, 32'h80000104);

    // immediate formats
    resp_q.push_back('{data: 32'h000012b7, err: 1'b0});
    resp_q.push_back('{data: 32'h008000ef, err: 1'b0});
    resp_q.push_back('{data: 32'h00112023, err: 1'b0});
    resp_q.push_back('{data: 32'h00309093, err: 1'b0});
    resp_q.push_back('{data: 32'h30002573, err: 1'b0});
    for (int i = 0; i < 60 && (resp_q.size() != 0 || exp_q.size() != 0); i++) step();
    check("imm_drain", 32'(resp_q.size() + exp_q.size()), 32'd0);

    // reset in the middle of a wait, late reply after release
    fix_delay = 5;
    wait_fire("pre_reset", 1'b0);
    step();
    #2 reset = 1'b1;
    #1;
    check("mid_rst_req_valid", {31'd0, io.io_mem_req_valid}, 32'd0);
    check("mid_rst_out_valid", {31'd0, io.io_out_valid}, 32'd0);
    check("mid_rst_inst", io.io_out_inst, 32'd0);
    check("mid_rst_pc", io.io_out_pc, 32'd0);
    check("mid_rst_fault", {31'd0, io.io_out_fault}, 32'd0);
    check("mid_rst_imm", {29'd0, io.io_imm_type}, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_pc = RESET_PC;
    outstanding = 1'b0;
    stale = 1'b0;
    exp_q.delete();
    io.io_mem_req_ready = 1'b0;
    io.io_out_ready = 1'b0;
    io.io_redirect_valid = 1'b0;
    io.io_mem_resp_valid = 1'b1;
    io.io_mem_resp_data = 32'h00500093;
    io.io_mem_resp_err = 1'b0;
    fix_delay = 0;
    wait_fire("post_reset", 1'b1);
    check("post_reset_addr", last_fire_addr, RESET_PC);

    // randomized traffic
    fix_delay = -1; max_delay = 4;
    p_ready = 60; p_oready = 60; p_redir = 6; p_spur = 10;
    for (int i = 0; i < 3000; i++) step();

    // drain
    p_redir = 0; p_spur = 0; p_ready = 100; p_oready = 100;
    for (int i = 0; i < 50 && (outstanding || exp_q.size() != 0 || io.io_out_valid); i++) step();
    check("final_drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
